dmi_target_model: RTL and testbench
===================================

// Module: dmi_target_model
// PURPOSE
//  Responder end of the debug module interface (DMI) request/response channel.
//  It accepts one DMI request at a time and applies reads/writes to a small register window.
//  After a programmable latency it returns a response.
//  Sits opposite a DMI initiator (sim DTM or JTAG DTM) in unit benches and standalone sims, standing in for the debug module.
// PARAMETERS
//  ADDR_W        7   DMI address width
//  DATA_W        32  DMI data width
//  REG_BASE      4   first DMI address backed by a register (7'h04)
//  NUM_REGS      16  registers in window; REG_BASE+NUM_REGS <= 2**ADDR_W
//  RESP_LATENCY  2   idle cycles between request accept and resp_valid (0 allowed)
// PORTS
//  clk                   in   1       clock
//  reset                 in   1       synchronous reset, ACTIVE-LOW (asserted when 0)
//  debug_req_valid       in   1       request valid
//  debug_req_ready       out  1       request ready
//  debug_req_bits_addr   in   ADDR_W  request address
//  debug_req_bits_op     in   2       0 nop, 1 read, 2 write, 3 reserved
//  debug_req_bits_data   in   DATA_W  write data
//  debug_resp_valid      out  1       response valid
//  debug_resp_ready      in   1       response ready
//  debug_resp_bits_resp  out  2       0 success, 2 failed, 3 busy
//  debug_resp_bits_data  out  DATA_W  read data (0 for non-read or failed)
//  busy_inject           in   1       sampled at accept: force busy response, no side effect
//  txn_count             out  32      completed response handshakes, wraps 2^32-1 -> 0
// BEHAVIOUR
//  - FSM: IDLE -> WAIT (if RESP_LATENCY>0) -> RESP -> IDLE; no other states.
//  - Reset (reset==0 at posedge): state=IDLE, all regs=0, txn_count=0, req_ready=0, resp_valid=0, resp/data outputs=0.
//    * Reset overrides any in-flight request; that request's response is discarded.
//  - req_ready is registered: 1 only in IDLE, except on the first cycle after reset deassert, when it is 0.
//    * req_ready never depends combinationally on req_valid or resp_ready.
//  - Accept when req_valid & req_ready at posedge. All request fields are sampled at that edge.
//    * Write commits to the register in the same edge.
//    * Read data is snapshotted in the same edge.
//  - Decode at accept, in priority order:
//    * busy_inject=1 -> resp=3, data=0, no write.
//    * op=0 -> resp=0, data=0.
//    * op=3 -> resp=2, data=0.
//    * addr outside [REG_BASE, REG_BASE+NUM_REGS) -> resp=2, data=0, no write.
//      Compare in ADDR_W+1 bits so there is no wrap.
//    * op=1 -> resp=0, data=reg[addr-REG_BASE].
//    * op=2 -> resp=0, data=0, reg[addr-REG_BASE]<=req data.
//  - Latency: accept at edge N -> resp_valid=1 from edge N+1+RESP_LATENCY.
//    * WAIT counter counts RESP_LATENCY cycles, width $clog2(RESP_LATENCY+1), min 1 bit.
//  - RESP: resp_valid, resp and data are held stable until resp_ready=1 at a posedge.
//    * That edge: txn_count+1, state->IDLE, resp_valid->0, resp/data outputs->0.
//  - Throughput: at most one outstanding request; minimum accept-to-accept spacing is RESP_LATENCY+3 cycles when resp_ready is tied high.
//  - resp_ready high outside RESP is ignored. req_valid outside IDLE is not accepted and is not dropped: the initiator holds it.
//  - A read after a write to the same address returns the written value (write committed before the read's accept).
// TESTING
//  1 Reset: hold reset=0 for 3 cycles while req_valid=1 -> req_ready=0, resp_valid=0, txn_count=0.
//    Release reset -> req_ready=0 on the first cycle, 1 from the second.
//  2 Write 0xDEADBEEF to addr 0x05, then read 0x05 (latency 2, resp_ready=1) ->
//    write resp=0 at accept+3; read resp=0, data=0xDEADBEEF; txn_count=2.
//  3 Read addr 0x03 and addr 0x14 -> resp=2, data=0. Then write 0x14 and read 0x13 -> resp=0, data=0 (0x13 unchanged).
//  4 busy_inject=1 on a write 0x55 to addr 0x04 -> resp=3. A following read of 0x04 -> data=0.
//  5 Backpressure: hold resp_ready=0 for 10 cycles in RESP -> resp_valid, resp and data stay stable, req_ready stays 0.
//    Then resp_ready=1 -> single handshake, txn_count+1.
//  6 Reset mid-WAIT after a write is accepted -> no response emitted, register reads back 0, txn_count=0.
//    Also with RESP_LATENCY=0 -> resp_valid at accept+1.

Source files
------------

// File: rtl/dmi_target_model.sv
// -----------------------------------------------------------------------------
// dmi_target_model
//
// Purpose:
//   Responder side of the debug module interface (DMI) request/response
//   channel. Stands in for the debug module opposite a DMI initiator (sim DTM
//   or JTAG DTM). It accepts one request at a time, applies reads/writes to a
//   small register window and returns a response after RESP_LATENCY idle
//   cycles.
//
// Ports:
//   clk                  in   1       clock
//   reset                in   1       synchronous reset, active low
//   debug_req_valid      in   1       request valid
//   debug_req_ready      out  1       request ready (registered)
//   debug_req_bits_addr  in   ADDR_W  request address
//   debug_req_bits_op    in   2       0 nop, 1 read, 2 write, 3 reserved
//   debug_req_bits_data  in   DATA_W  write data
//   debug_resp_valid     out  1       response valid
//   debug_resp_ready     in   1       response ready
//   debug_resp_bits_resp out  2       0 success, 2 failed, 3 busy
//   debug_resp_bits_data out  DATA_W  read data (0 for non-read or failed)
//   busy_inject          in   1       sampled at accept: force busy, no effect
//   txn_count            out  32      completed response handshakes (wraps)
// -----------------------------------------------------------------------------
module dmi_target_model #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int REG_BASE     = 4,
  parameter int NUM_REGS     = 16,
  parameter int RESP_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              debug_req_valid,
  output logic              debug_req_ready,
  input  logic [ADDR_W-1:0] debug_req_bits_addr,
  input  logic [1:0]        debug_req_bits_op,
  input  logic [DATA_W-1:0] debug_req_bits_data,
  output logic              debug_resp_valid,
  input  logic              debug_resp_ready,
  output logic [1:0]        debug_resp_bits_resp,
  output logic [DATA_W-1:0] debug_resp_bits_data,
  input  logic              busy_inject,
  output logic [31:0]       txn_count
);

  localparam int CNT_W = (RESP_LATENCY > 0) ? $clog2(RESP_LATENCY + 1) : 1;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Window bounds are compared one bit wider than the address so that
  // REG_BASE+NUM_REGS reaching 2**ADDR_W cannot wrap to a small value.
  localparam logic [ADDR_W:0] WIN_LO = (ADDR_W + 1)'(REG_BASE);
  localparam logic [ADDR_W:0] WIN_HI = (ADDR_W + 1)'(REG_BASE + NUM_REGS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic [1:0]         resp_q, resp_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [1:0]         pend_resp_q, pend_resp_d;
  logic [DATA_W-1:0]  pend_data_q, pend_data_d;
  logic [31:0]        txn_q, txn_d;
  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];

  logic [ADDR_W:0]    addr_ext;
  logic               in_range;
  logic [IDX_W-1:0]   idx;

  assign addr_ext = {1'b0, debug_req_bits_addr};
  assign in_range = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
  assign idx      = IDX_W'(addr_ext - WIN_LO);

  // Next-state logic. The decoded response is parked in pend_* at accept and
  // only copied onto the outputs on the cycle resp_valid rises, so the outputs
  // read as zero whenever no response is being presented. Entering RESP one
  // cycle before resp_valid rises gives the accept+1+RESP_LATENCY timing even
  // when RESP_LATENCY is zero and WAIT is skipped.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    data_d       = data_q;
    pend_resp_d  = pend_resp_q;
    pend_data_d  = pend_data_q;
    txn_d        = txn_q;
    regs_d       = regs_q;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (debug_req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          cnt_d       = CNT_W'(1);
          state_d     = (RESP_LATENCY > 0) ? WAIT : RESP;
          pend_resp_d = 2'd0;
          pend_data_d = '0;
          if (busy_inject) begin
            pend_resp_d = 2'd3;
          end else if (debug_req_bits_op == 2'd0) begin
            pend_resp_d = 2'd0;
          end else if (debug_req_bits_op == 2'd3) begin
            pend_resp_d = 2'd2;
          end else if (!in_range) begin
            pend_resp_d = 2'd2;
          end else if (debug_req_bits_op == 2'd1) begin
            pend_data_d = regs_q[idx];
          end else begin
            regs_d[idx] = debug_req_bits_data;
          end
        end
      end

      WAIT: begin
        if (cnt_q == CNT_W'(RESP_LATENCY)) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
          resp_d       = pend_resp_q;
          data_d       = pend_data_q;
        end else if (debug_resp_ready) begin
          resp_valid_d = 1'b0;
          resp_d       = 2'd0;
          data_d       = '0;
          txn_d        = txn_q + 32'd1;
          state_d      = IDLE;
          req_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b0;
      end
    endcase
  end

  // All state, including the register window, clears on reset; an in-flight
  // request is simply forgotten.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= 2'd0;
      data_q       <= '0;
      pend_resp_q  <= 2'd0;
      pend_data_q  <= '0;
      txn_q        <= 32'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      data_q       <= data_d;
      pend_resp_q  <= pend_resp_d;
      pend_data_q  <= pend_data_d;
      txn_q        <= txn_d;
      regs_q       <= regs_d;
    end
  end

  assign debug_req_ready      = req_ready_q;
  assign debug_resp_valid     = resp_valid_q;
  assign debug_resp_bits_resp = resp_q;
  assign debug_resp_bits_data = data_q;
  assign txn_count            = txn_q;

endmodule

// File: tb/tb_dmi_target_model.sv
// -----------------------------------------------------------------------------
// tb_dmi_target_model
//
// Purpose:
//   Self-checking bench for dmi_target_model. One instance uses the default
//   latency of 2, a second instance uses latency 0. Expected responses are
//   pushed to a scoreboard queue when a request is accepted and popped when
//   the DUT presents its response.
// -----------------------------------------------------------------------------
module tb_dmi_target_model;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid, req_ready;
  logic [6:0]  req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic        resp_valid, resp_ready;
  logic [1:0]  resp_resp;
  logic [31:0] resp_data;
  logic        busy;
  logic [31:0] txn;

  logic        z_req_valid, z_req_ready;
  logic [6:0]  z_req_addr;
  logic [1:0]  z_req_op;
  logic [31:0] z_req_data;
  logic        z_resp_valid, z_resp_ready;
  logic [1:0]  z_resp_resp;
  logic [31:0] z_resp_data;
  logic        z_busy;
  logic [31:0] z_txn;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_txn;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 18;
  localparam int LAT2_NEGEDGES = 4;

  exp_t sb_q[$];
  vec_t vecs[NV];

  always #5 clk = ~clk;

  dmi_target_model #(.RESP_LATENCY(2)) dut (
    .clk                  (clk),
    .reset                (reset),
    .debug_req_valid      (req_valid),
    .debug_req_ready      (req_ready),
    .debug_req_bits_addr  (req_addr),
    .debug_req_bits_op    (req_op),
    .debug_req_bits_data  (req_data),
    .debug_resp_valid     (resp_valid),
    .debug_resp_ready     (resp_ready),
    .debug_resp_bits_resp (resp_resp),
    .debug_resp_bits_data (resp_data),
    .busy_inject          (busy),
    .txn_count            (txn)
  );

  dmi_target_model #(.RESP_LATENCY(0)) dut0 (
    .clk                  (clk),
    .reset                (reset),
    .debug_req_valid      (z_req_valid),
    .debug_req_ready      (z_req_ready),
    .debug_req_bits_addr  (z_req_addr),
    .debug_req_bits_op    (z_req_op),
    .debug_req_bits_data  (z_req_data),
    .debug_resp_valid     (z_resp_valid),
    .debug_resp_ready     (z_resp_ready),
    .debug_resp_bits_resp (z_resp_resp),
    .debug_resp_bits_data (z_resp_data),
    .busy_inject          (z_busy),
    .txn_count            (z_txn)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge: present a request, wait for ready, record the
  // expected response at the accepting edge and release the request.
  task automatic applyStimulus(input logic [1:0] op, input logic [6:0] addr,
                               input logic [31:0] wdata, input logic bsy,
                               input logic [1:0] eresp, input logic [31:0] edata);
    exp_t e;
    int   n;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = wdata;
    busy      = bsy;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_timeout", 64'(n < 50), 64'd1);
    e.resp = eresp;
    e.data = edata;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    busy      = 1'b0;
    req_op    = 2'd0;
    req_data  = 32'd0;
  endtask

  // Waits for the response, checks accept-to-valid latency in negedges and
  // compares against the scoreboard head.
  task automatic checkOutput(input int exp_lat);
    exp_t e;
    int   lat;
    lat = 0;
    @(negedge clk);
    lat++;
    check("req_ready_busy", 64'(req_ready), 64'd0);
    while (!resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("resp_latency", 64'(lat), 64'(exp_lat));
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check("resp_code", 64'(resp_resp), 64'(e.resp));
      check("resp_data", 64'(resp_data), 64'(e.data));
    end
  endtask

  // With resp_ready high the next edge completes the handshake.
  task automatic finishHandshake();
    @(posedge clk);
    exp_txn = exp_txn + 32'd1;
    @(negedge clk);
    check("txn_count", 64'(txn), 64'(exp_txn));
    check("resp_valid_drop", 64'(resp_valid), 64'd0);
    check("resp_data_clear", 64'(resp_data), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    int n;
    logic [31:0] held_data;

    vecs[0]  = '{2'd2, 7'h05, 32'hDEADBEEF, 1'b0, 2'd0, 32'h0};
    vecs[1]  = '{2'd1, 7'h05, 32'h0,        1'b0, 2'd0, 32'hDEADBEEF};
    vecs[2]  = '{2'd1, 7'h03, 32'h0,        1'b0, 2'd2, 32'h0};
    vecs[3]  = '{2'd1, 7'h14, 32'h0,        1'b0, 2'd2, 32'h0};
    vecs[4]  = '{2'd2, 7'h14, 32'h12345678, 1'b0, 2'd2, 32'h0};
    vecs[5]  = '{2'd1, 7'h13, 32'h0,        1'b0, 2'd0, 32'h0};
    vecs[6]  = '{2'd2, 7'h04, 32'h55,       1'b1, 2'd3, 32'h0};
    vecs[7]  = '{2'd1, 7'h04, 32'h0,        1'b0, 2'd0, 32'h0};
    vecs[8]  = '{2'd0, 7'h05, 32'h0,        1'b0, 2'd0, 32'h0};
    vecs[9]  = '{2'd3, 7'h05, 32'h77,       1'b0, 2'd2, 32'h0};
    vecs[10] = '{2'd1, 7'h05, 32'h0,        1'b1, 2'd3, 32'h0};
    vecs[11] = '{2'd2, 7'h13, 32'hA5A5A5A5, 1'b0, 2'd0, 32'h0};
    vecs[12] = '{2'd1, 7'h13, 32'h0,        1'b0, 2'd0, 32'hA5A5A5A5};
    vecs[13] = '{2'd2, 7'h04, 32'h11,       1'b0, 2'd0, 32'h0};
    vecs[14] = '{2'd1, 7'h04, 32'h0,        1'b0, 2'd0, 32'h11};
    vecs[15] = '{2'd1, 7'h05, 32'h0,        1'b0, 2'd0, 32'hDEADBEEF};
    vecs[16] = '{2'd2, 7'h7F, 32'h1,        1'b0, 2'd2, 32'h0};
    vecs[17] = '{2'd1, 7'h7F, 32'h0,        1'b0, 2'd2, 32'h0};

    reset        = 1'b0;
    req_valid    = 1'b1;
    req_addr     = 7'h05;
    req_op       = 2'd1;
    req_data     = 32'd0;
    busy         = 1'b0;
    resp_ready   = 1'b1;
    z_req_valid  = 1'b1;
    z_req_addr   = 7'h05;
    z_req_op     = 2'd1;
    z_req_data   = 32'd0;
    z_busy       = 1'b0;
    z_resp_ready = 1'b1;
    exp_txn      = 32'd0;

    // Reset held with a pending request.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_txn", 64'(txn), 64'd0);
    end
    reset       = 1'b1;
    req_valid   = 1'b0;
    z_req_valid = 1'b0;
    #1;
    check("rel_first_ready", 64'(req_ready), 64'd0);
    check("rel_first_ready_l0", 64'(z_req_ready), 64'd0);
    @(negedge clk);
    check("rel_second_ready", 64'(req_ready), 64'd1);
    check("rel_second_ready_l0", 64'(z_req_ready), 64'd1);

    // Table-driven transactions, resp_ready tied high.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].busy,
                    vecs[i].exp_resp, vecs[i].exp_data);
      checkOutput(LAT2_NEGEDGES);
      finishHandshake();
    end

    // Backpressure: response must hold while resp_ready is low.
    resp_ready = 1'b0;
    applyStimulus(2'd1, 7'h13, 32'h0, 1'b0, 2'd0, 32'hA5A5A5A5);
    checkOutput(LAT2_NEGEDGES);
    held_data = resp_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_valid", 64'(resp_valid), 64'd1);
      check("bp_resp", 64'(resp_resp), 64'd0);
      check("bp_data", 64'(resp_data), 64'(held_data));
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    check("bp_txn_hold", 64'(txn), 64'(exp_txn));
    resp_ready = 1'b1;
    finishHandshake();
    @(negedge clk);
    check("bp_single_handshake", 64'(txn), 64'(exp_txn));

    // Reset while a write sits in WAIT: response dropped, register cleared.
    applyStimulus(2'd2, 7'h06, 32'hCAFEF00D, 1'b0, 2'd0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    exp_txn = 32'd0;
    check("midrst_txn", 64'(txn), 64'd0);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    check("midrst_no_resp", 64'(cnt), 64'd0);
    check("midrst_txn_after", 64'(txn), 64'd0);
    applyStimulus(2'd1, 7'h06, 32'h0, 1'b0, 2'd0, 32'h0);
    checkOutput(LAT2_NEGEDGES);
    finishHandshake();

    // Zero-latency instance: valid appears one edge after accept.
    for (int k = 0; k < 2; k++) begin
      z_req_valid = 1'b1;
      z_req_op    = (k == 0) ? 2'd2 : 2'd1;
      z_req_addr  = 7'h07;
      z_req_data  = (k == 0) ? 32'h00001234 : 32'h0;
      n = 0;
      while (!z_req_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("l0_req_ready_timeout", 64'(n < 50), 64'd1);
      @(posedge clk);
      #1;
      z_req_valid = 1'b0;
      @(negedge clk);
      check("l0_not_yet_valid", 64'(z_resp_valid), 64'd0);
      @(negedge clk);
      check("l0_valid", 64'(z_resp_valid), 64'd1);
      check("l0_resp", 64'(z_resp_resp), 64'd0);
      check("l0_data", 64'(z_resp_data), (k == 0) ? 64'h0 : 64'h1234);
      @(negedge clk);
      check("l0_txn", 64'(z_txn), 64'(k + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
